// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Per-GPR scoreboard sitting beside the ID stage. Counts register writes in
// flight between ID issue and WB retire, and separately counts long-latency
// writes (load/mul/div/csr) whose result is not yet forwardable.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   flush                discard all in-flight state (err is kept)
//   id_fire              instruction leaves ID this cycle
//   id_rf_raddr1/2       ID source registers
//   id_rf_we/waddr       ID destination write enable / register
//   id_long_lat          ID result unforwardable until a ready event
//   rdy_valid/waddr      a long-latency result became forwardable
//   wb_valid/rf_we/waddr WB retire of a GPR write
//   rs1_pending/rs2_pending  source has at least one in-flight write
//   stall                ID must not fire
//   busy_vec             bit i set when reg i has any in-flight write
//   err                  sticky counter-underflow flag
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                id_fire,
  input  logic [4:0]          id_rf_raddr1,
  input  logic [4:0]          id_rf_raddr2,
  input  logic                id_rf_we,
  input  logic [4:0]          id_rf_waddr,
  input  logic                id_long_lat,
  input  logic                rdy_valid,
  input  logic [4:0]          rdy_waddr,
  input  logic                wb_valid,
  input  logic                wb_rf_we,
  input  logic [4:0]          wb_rf_waddr,
  output logic                rs1_pending,
  output logic                rs2_pending,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] pend_cnt [NUM_REGS];
  logic [CNT_W-1:0] ll_cnt   [NUM_REGS];
  logic [CNT_W-1:0] pend_nxt [NUM_REGS];
  logic [CNT_W-1:0] ll_nxt   [NUM_REGS];
  logic             err_nxt;

  logic issue_ok;
  logic ll_issue;
  logic rdy_ev;
  logic ret_ev;
  logic src_stall;
  logic dst_stall;

  // Hazard detection uses registered state only; same-cycle ready/retire
  // events are deliberately not bypassed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    src_stall   = 1'b0;
    dst_stall   = 1'b0;
    busy_vec    = '0;

    if (id_rf_raddr1 != 5'd0) begin
      rs1_pending = (pend_cnt[id_rf_raddr1] != '0);
      src_stall   = (ll_cnt[id_rf_raddr1] != '0);
    end
    if (id_rf_raddr2 != 5'd0) begin
      rs2_pending = (pend_cnt[id_rf_raddr2] != '0);
      src_stall   = src_stall | (ll_cnt[id_rf_raddr2] != '0);
    end
    // Refuse an issue that would wrap a destination counter.
    if (id_rf_waddr != 5'd0) begin
      dst_stall = (id_rf_we    & (pend_cnt[id_rf_waddr] == CNT_MAX)) |
                  (id_long_lat & (ll_cnt[id_rf_waddr]   == CNT_MAX));
    end
    stall = src_stall | dst_stall;

    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (pend_cnt[i] != '0);
    end
  end

  assign issue_ok = id_fire & ~stall & id_rf_we & (id_rf_waddr != 5'd0);
  assign ll_issue = issue_ok & id_long_lat;
  assign rdy_ev   = rdy_valid & (rdy_waddr != 5'd0);
  assign ret_ev   = wb_valid & wb_rf_we & (wb_rf_waddr != 5'd0);

  // Next counter values. An increment and decrement on the same register
  // cancel; a lone decrement at zero saturates and flags err. Flush wins
  // over every event, so a discarded decrement cannot raise err.
  always_comb begin
    err_nxt = err;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_nxt[i] = pend_cnt[i];
      ll_nxt[i]   = ll_cnt[i];
    end

    for (int i = 1; i < NUM_REGS; i++) begin
      automatic logic p_inc = issue_ok & (id_rf_waddr == 5'(i));
      automatic logic p_dec = ret_ev   & (wb_rf_waddr == 5'(i));
      automatic logic l_inc = ll_issue & (id_rf_waddr == 5'(i));
      automatic logic l_dec = rdy_ev   & (rdy_waddr   == 5'(i));

      if (p_inc && !p_dec) begin
        pend_nxt[i] = pend_cnt[i] + 1'b1;
      end else if (p_dec && !p_inc) begin
        if (pend_cnt[i] == '0) err_nxt = 1'b1;
        else                   pend_nxt[i] = pend_cnt[i] - 1'b1;
      end

      if (l_inc && !l_dec) begin
        ll_nxt[i] = ll_cnt[i] + 1'b1;
      end else if (l_dec && !l_inc) begin
        if (ll_cnt[i] == '0) err_nxt = 1'b1;
        else                 ll_nxt[i] = ll_cnt[i] - 1'b1;
      end
    end

    if (flush) begin
      err_nxt = err;
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_nxt[i] = '0;
        ll_nxt[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: these arrays are plain flops, not RAM, so clearing every entry
      // on reset is legal and required for a known in-flight count.
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_cnt[i] <= '0;
        ll_cnt[i]   <= '0;
      end
      err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_cnt[i] <= pend_nxt[i];
        ll_cnt[i]   <= ll_nxt[i];
      end
      err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard. Inputs change 1 ns after each rising
// edge; outputs are sampled 1 ns later, well away from the next edge.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        id_fire;
  logic [4:0]  id_rf_raddr1;
  logic [4:0]  id_rf_raddr2;
  logic        id_rf_we;
  logic [4:0]  id_rf_waddr;
  logic        id_long_lat;
  logic        rdy_valid;
  logic [4:0]  rdy_waddr;
  logic        wb_valid;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        stall;
  logic [31:0] busy_vec;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .id_fire      (id_fire),
    .id_rf_raddr1 (id_rf_raddr1),
    .id_rf_raddr2 (id_rf_raddr2),
    .id_rf_we     (id_rf_we),
    .id_rf_waddr  (id_rf_waddr),
    .id_long_lat  (id_long_lat),
    .rdy_valid    (rdy_valid),
    .rdy_waddr    (rdy_waddr),
    .wb_valid     (wb_valid),
    .wb_rf_we     (wb_rf_we),
    .wb_rf_waddr  (wb_rf_waddr),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending),
    .stall        (stall),
    .busy_vec     (busy_vec),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; id_fire = 1'b0;
    id_rf_raddr1 = '0; id_rf_raddr2 = '0; id_rf_we = 1'b0; id_rf_waddr = '0;
    id_long_lat = 1'b0; rdy_valid = 1'b0; rdy_waddr = '0;
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    tick(); tick();
    resetn = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_busy",  busy_vec,   32'd0);
      check("idle_err",   32'(err),   32'd0);
    end

    // Short-latency write to r4, then retire
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd4;
    settle();
    check("r4_issue_stall", 32'(stall), 32'd0);
    tick();
    id_fire = 1'b0; id_rf_we = 1'b0; id_rf_waddr = '0; id_rf_raddr1 = 5'd4;
    settle();
    check("r4_rs1_pending", 32'(rs1_pending), 32'd1);
    check("r4_no_stall",    32'(stall),       32'd0);
    check("r4_busy",        busy_vec,         32'h0000_0010);
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = 5'd4;
    tick();
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    settle();
    check("r4_retired_busy", busy_vec,         32'd0);
    check("r4_retired_rs1",  32'(rs1_pending), 32'd0);

    // Long-latency load to r5
    id_rf_raddr1 = '0;
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd5; id_long_lat = 1'b1;
    tick();
    id_fire = 1'b0; id_rf_we = 1'b0; id_rf_waddr = '0; id_long_lat = 1'b0;
    id_rf_raddr2 = 5'd5;
    settle();
    check("r5_ll_stall",   32'(stall),       32'd1);
    check("r5_rs2_pend",   32'(rs2_pending), 32'd1);
    rdy_valid = 1'b1; rdy_waddr = 5'd5;
    settle();
    check("r5_rdy_same_cycle_stall", 32'(stall), 32'd1);
    tick();
    rdy_valid = 1'b0; rdy_waddr = '0;
    settle();
    check("r5_rdy_released", 32'(stall),       32'd0);
    check("r5_still_pend",   32'(rs2_pending), 32'd1);
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = 5'd5;
    tick();
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    settle();
    check("r5_retired_pend", 32'(rs2_pending), 32'd0);
    id_rf_raddr2 = '0;

    // Counter saturation on r7
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd7;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("r7_fill_stall", 32'(stall), 32'd0);
      tick();
    end
    settle();
    check("r7_full_stall", 32'(stall), 32'd1);
    tick();
    settle();
    check("r7_no_wrap_stall", 32'(stall), 32'd1);
    id_fire = 1'b0;
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = 5'd7;
    settle();
    check("r7_retire_same_cycle", 32'(stall), 32'd1);
    tick();
    wb_valid = 1'b0;
    settle();
    check("r7_released", 32'(stall), 32'd0);
    id_rf_we = 1'b0; id_rf_waddr = '0;
    // Exactly two writes remain
    wb_valid = 1'b1;
    tick();
    settle();
    check("r7_one_left", busy_vec, 32'h0000_0080);
    tick();
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    settle();
    check("r7_drained", busy_vec, 32'd0);
    check("r7_no_err",  32'(err), 32'd0);

    // Simultaneous issue and retire on r9
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd9;
    tick();
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = 5'd9;
    tick();
    id_fire = 1'b0; id_rf_we = 1'b0; id_rf_waddr = '0;
    wb_valid = 1'b1;
    id_rf_raddr1 = 5'd9;
    settle();
    check("r9_cancel_busy", busy_vec,         32'h0000_0200);
    check("r9_cancel_rs1",  32'(rs1_pending), 32'd1);
    tick();
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    settle();
    check("r9_drained", busy_vec, 32'd0);

    // r0 is never tracked
    id_rf_raddr1 = '0;
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = '0; id_long_lat = 1'b1;
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = '0;
    rdy_valid = 1'b1; rdy_waddr = '0;
    tick();
    id_fire = 1'b0; id_rf_we = 1'b0; id_long_lat = 1'b0;
    wb_valid = 1'b0; wb_rf_we = 1'b0; rdy_valid = 1'b0;
    settle();
    check("r0_busy",  busy_vec,         32'd0);
    check("r0_err",   32'(err),         32'd0);
    check("r0_rs1",   32'(rs1_pending), 32'd0);
    check("r0_stall", 32'(stall),       32'd0);

    // Flush with r3, r5 long-latency pending and a same-cycle issue to r6
    id_fire = 1'b1; id_rf_we = 1'b1; id_long_lat = 1'b1; id_rf_waddr = 5'd3;
    tick();
    id_rf_waddr = 5'd5;
    tick();
    id_fire = 1'b0; id_rf_we = 1'b0; id_long_lat = 1'b0; id_rf_waddr = '0;
    id_rf_raddr1 = 5'd3; id_rf_raddr2 = 5'd5;
    settle();
    check("pre_flush_stall", 32'(stall), 32'd1);
    check("pre_flush_busy",  busy_vec,   32'h0000_0028);
    id_rf_raddr1 = '0; id_rf_raddr2 = '0;
    flush = 1'b1; id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd6;
    tick();
    flush = 1'b0; id_fire = 1'b0; id_rf_we = 1'b0; id_rf_waddr = '0;
    id_rf_raddr1 = 5'd3; id_rf_raddr2 = 5'd5;
    settle();
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_busy",  busy_vec,   32'd0);
    check("flush_err",   32'(err),   32'd0);

    // Underflow sets sticky err
    id_rf_raddr1 = '0; id_rf_raddr2 = '0;
    wb_valid = 1'b1; wb_rf_we = 1'b1; wb_rf_waddr = 5'd3;
    tick();
    wb_valid = 1'b0; wb_rf_we = 1'b0; wb_rf_waddr = '0;
    settle();
    check("underflow_err",  32'(err), 32'd1);
    check("underflow_busy", busy_vec, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("err_survives_flush", 32'(err), 32'd1);
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // Reset mid-operation clears err and counters
    id_fire = 1'b1; id_rf_we = 1'b1; id_rf_waddr = 5'd12;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; id_fire = 1'b0; id_rf_we = 1'b0; id_rf_waddr = '0;
    settle();
    check("reset_err",  32'(err), 32'd0);
    check("reset_busy", busy_vec, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Per-GPR scoreboard. Tracks register writes that are in flight between ID issue and WB retire.
- Tells ID whether each source operand is pending, which means a bypass value must be used.
- Raises the ID stall when a source's producer is long-latency (load/mul/div/csr) and its result is not yet forwardable, or when a destination counter would overflow.
- Sits beside the ID stage. Its stall output gates ID ready_go.

Parameters:
NUM_REGS, 32, number of architectural GPRs; r0 never tracked
CNT_W, 2, per-register counter width; max in-flight writes per reg = 2^CNT_W-1

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
flush  input  1  pipeline flush (exception/ertn); discards all in-flight state
id_fire  input  1  instruction leaves ID this cycle
id_rf_raddr1  input  5  source reg 1 of ID instruction
id_rf_raddr2  input  5  source reg 2 of ID instruction
id_rf_we  input  1  ID instruction writes GPR
id_rf_waddr  input  5  ID destination reg
id_long_lat  input  1  ID instruction's result is unforwardable until ready event
rdy_valid  input  1  a long-latency result became forwardable this cycle
rdy_waddr  input  5  destination of that result
wb_valid  input  1  WB instruction retires this cycle
wb_rf_we  input  1  retiring instruction writes GPR
wb_rf_waddr  input  5  retiring destination
rs1_pending  output  1  raddr1 has ≥1 in-flight write
rs2_pending  output  1  raddr2 has ≥1 in-flight write
stall  output  1  ID must not fire
busy_vec  output  NUM_REGS  bit i = pend_cnt[i]!=0
err  output  1  sticky: retire or ready event with counter already 0

Behaviour:
State
- pend_cnt[i] is the count of in-flight writes to reg i. ll_cnt[i] is the count of in-flight unready long-latency writes to reg i. Both are CNT_W bits wide.
- Index 0 is never written; it reads as 0.

Reset
- When resetn=0 at a clk edge, all counters are cleared and err=0.
- The outputs then read rs1_pending=0, rs2_pending=0, stall=0 and busy_vec=0.

Combinational outputs
- All outputs come from registered state only. Same-cycle rdy/wb events are not bypassed, so a stall releases one cycle after the event.
- rsN_pending = (raddrN!=0) & (pend_cnt[raddrN]!=0).
- stall = ((raddr1!=0) & ll_cnt[raddr1]!=0) | ((raddr2!=0) & ll_cnt[raddr2]!=0) | (id_rf_we & waddr!=0 & pend_cnt[waddr]==max) | (id_long_lat & waddr!=0 & ll_cnt[waddr]==max).
- Source checks use pre-issue state. An instruction never stalls on its own destination.

Issue
- issue_ok = id_fire & ~stall & id_rf_we & (id_rf_waddr!=0).
- When id_fire=1 while stall=1, the issue is ignored and no counter changes.
- On issue_ok: pend_cnt[waddr]+1. If id_long_lat is also set: ll_cnt[waddr]+1.

Ready
- rdy_valid & rdy_waddr!=0 → ll_cnt[rdy_waddr]-1.

Retire
- wb_valid & wb_rf_we & wb_rf_waddr!=0 → pend_cnt[wb_rf_waddr]-1.

Simultaneous events on the same reg
- Increment and decrement cancel, leaving the counter unchanged.
- Events on different regs apply independently.

Underflow
- A decrement of a counter already at 0 leaves it at 0 and sets err.
- err clears only on reset.

Flush
- All counters are 0 next cycle. Flush overrides any issue/rdy/retire in the same cycle.
- err is not cleared by flush.

Reset mid-operation
- Reset has priority over flush and all events.

Test Plan:
- Reset then idle → stall=0, busy_vec=0, err=0 for 5 cycles.
- Issue add r4 (we, !long_lat); next cycle raddr1=4 → rs1_pending=1, stall=0. Retire r4 → busy_vec[4]=0 next cycle.
- Issue ld r5 (long_lat); next cycle raddr2=5 → stall=1. Pulse rdy_valid with rdy_waddr=5 → stall still 1 that cycle, 0 the next; rs2_pending stays 1 until WB retires r5.
- Issue three writes to r7 without retire → pend_cnt[7]=3. A fourth id_fire to r7 → stall=1 and no increment. One retire → stall drops the following cycle.
- Same cycle: issue to r9 and retire r9 with pend_cnt[9]=1 → pend_cnt[9] stays 1. Issue/retire with waddr=0 → no state change, rs1_pending=0 for raddr1=0.
- With r3 and r5 long-lat pending, assert flush with a simultaneous issue to r6 → all counters 0 next cycle, stall=0. A retire on r3 with counter 0 → err=1 and stays 1 through a later flush.
